// File: rtl/bp_me_cord_id_req_arb_if.sv
// ----------------------------------------------------------------------------
// bp_me_cord_id_req_arb_if
//   Request/response bundle between ME clients and the cord->ID request
//   arbiter.
//   slave modport  : the arbiter (consumes requests, produces responses)
//   master modport : the clients / response consumer
//   Signals:
//     req_v        per-client request valid
//     req_cord     per-client cord, client i at [i*cord_width_p +: cord_width_p]
//     req_ready    one-hot grant back to the clients
//     resp_v       response valid
//     resp_tag     index of the served client
//     resp_*_id*   captured translator results
//     resp_yumi    consumer accepts the response
// ----------------------------------------------------------------------------
interface bp_me_cord_id_req_arb_if #(
  parameter int num_req_p       = 4,
  parameter int cord_width_p    = 5,
  parameter int core_id_width_p = 2,
  parameter int cce_id_width_p  = 4,
  parameter int lce_id_width_p  = 6,
  parameter int tag_width_p     = $clog2(num_req_p)
) ();

  logic [num_req_p-1:0]              req_v;
  logic [num_req_p*cord_width_p-1:0] req_cord;
  logic [num_req_p-1:0]              req_ready;

  logic                              resp_v;
  logic [tag_width_p-1:0]            resp_tag;
  logic [core_id_width_p-1:0]        resp_core_id;
  logic [cce_id_width_p-1:0]         resp_cce_id;
  logic [lce_id_width_p-1:0]         resp_lce_id0;
  logic [lce_id_width_p-1:0]         resp_lce_id1;
  logic                              resp_yumi;

  modport slave (
    input  req_v, req_cord, resp_yumi,
    output req_ready, resp_v, resp_tag, resp_core_id, resp_cce_id,
           resp_lce_id0, resp_lce_id1
  );

  modport master (
    output req_v, req_cord, resp_yumi,
    input  req_ready, resp_v, resp_tag, resp_core_id, resp_cce_id,
           resp_lce_id0, resp_lce_id1
  );

endinterface

// File: rtl/bp_me_cord_id_req_arb.sv
// ----------------------------------------------------------------------------
// bp_me_cord_id_req_arb
//   Shares one combinational cord->ID translator among num_req_p ME clients.
//   A round-robin grant picks one requesting client, its cord is registered
//   onto cord_o, the translator result is captured one cycle later and held
//   on a valid/yumi response port together with the requester's index.
//
//   Ports:
//     clk_i, reset_n_i  clock (rising edge), async active-low reset
//     arb_if (slave)    request valid/cord/ready and response valid/tag/IDs/yumi
//     cord_o            registered cord driven into the translator
//     core_id_i, cce_id_i, lce_id0_i, lce_id1_i   translator results
//
//   Optional feature: define BP_ME_CORD_ID_CACHE_EN to add a one-entry
//   last-result cache; a request whose cord matches the cached cord skips the
//   LOOKUP cycle and responds one cycle earlier.
// ----------------------------------------------------------------------------
module bp_me_cord_id_req_arb #(
  parameter int num_req_p       = 4,
  parameter int cord_width_p    = 5,
  parameter int core_id_width_p = 2,
  parameter int cce_id_width_p  = 4,
  parameter int lce_id_width_p  = 6,
  parameter int tag_width_p     = $clog2(num_req_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  bp_me_cord_id_req_arb_if.slave     arb_if,
  output logic [cord_width_p-1:0]    cord_o,
  input  logic [core_id_width_p-1:0] core_id_i,
  input  logic [cce_id_width_p-1:0]  cce_id_i,
  input  logic [lce_id_width_p-1:0]  lce_id0_i,
  input  logic [lce_id_width_p-1:0]  lce_id1_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [tag_width_p-1:0]     ptr_q, ptr_d;
  logic [tag_width_p-1:0]     tag_q, tag_d;
  logic [cord_width_p-1:0]    cord_q, cord_d;
  logic [core_id_width_p-1:0] core_q, core_d;
  logic [cce_id_width_p-1:0]  cce_q, cce_d;
  logic [lce_id_width_p-1:0]  lce0_q, lce0_d;
  logic [lce_id_width_p-1:0]  lce1_q, lce1_d;

`ifdef BP_ME_CORD_ID_CACHE_EN
  logic                       cache_v_q, cache_v_d;
  logic [cord_width_p-1:0]    cache_cord_q, cache_cord_d;
  logic [core_id_width_p-1:0] cache_core_q, cache_core_d;
  logic [cce_id_width_p-1:0]  cache_cce_q, cache_cce_d;
  logic [lce_id_width_p-1:0]  cache_lce0_q, cache_lce0_d;
  logic [lce_id_width_p-1:0]  cache_lce1_q, cache_lce1_d;
`endif

  logic [num_req_p-1:0]       gnt;
  logic [tag_width_p-1:0]     gnt_idx;
  logic                       gnt_found;
  logic [cord_width_p-1:0]    gnt_cord;

  // Round-robin search starting at the pointer; first valid client wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      if (!gnt_found && arb_if.req_v[(int'(ptr_q) + k) % num_req_p]) begin
        gnt_found = 1'b1;
        gnt_idx   = tag_width_p'((int'(ptr_q) + k) % num_req_p);
      end
    end
    gnt[gnt_idx] = gnt_found;
  end

  assign gnt_cord = arb_if.req_cord[gnt_idx*cord_width_p +: cord_width_p];

  // The grant is only offered while idle, so any asserted grant bit is also
  // a completed handshake with a valid client.
  assign arb_if.req_ready = (state_q == IDLE) ? gnt : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tag_d   = tag_q;
    cord_d  = cord_q;
    core_d  = core_q;
    cce_d   = cce_q;
    lce0_d  = lce0_q;
    lce1_d  = lce1_q;
`ifdef BP_ME_CORD_ID_CACHE_EN
    cache_v_d    = cache_v_q;
    cache_cord_d = cache_cord_q;
    cache_core_d = cache_core_q;
    cache_cce_d  = cache_cce_q;
    cache_lce0_d = cache_lce0_q;
    cache_lce1_d = cache_lce1_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          cord_d = gnt_cord;
          tag_d  = gnt_idx;
          ptr_d  = (int'(gnt_idx) == num_req_p - 1) ? '0
                                                    : gnt_idx + tag_width_p'(1);
`ifdef BP_ME_CORD_ID_CACHE_EN
          if (cache_v_q && (gnt_cord == cache_cord_q)) begin
            core_d  = cache_core_q;
            cce_d   = cache_cce_q;
            lce0_d  = cache_lce0_q;
            lce1_d  = cache_lce1_q;
            state_d = RESP;
          end else begin
            state_d = LOOKUP;
          end
`else
          state_d = LOOKUP;
`endif
        end
      end
      LOOKUP: begin
        // cord_o has been stable for this whole cycle, so the translator
        // output is settled at the closing edge.
        core_d  = core_id_i;
        cce_d   = cce_id_i;
        lce0_d  = lce_id0_i;
        lce1_d  = lce_id1_i;
        state_d = RESP;
`ifdef BP_ME_CORD_ID_CACHE_EN
        cache_v_d    = 1'b1;
        cache_cord_d = cord_q;
        cache_core_d = core_id_i;
        cache_cce_d  = cce_id_i;
        cache_lce0_d = lce_id0_i;
        cache_lce1_d = lce_id1_i;
`endif
      end
      RESP: begin
        if (arb_if.resp_yumi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      tag_q   <= '0;
      cord_q  <= '0;
      core_q  <= '0;
      cce_q   <= '0;
      lce0_q  <= '0;
      lce1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      cord_q  <= cord_d;
      core_q  <= core_d;
      cce_q   <= cce_d;
      lce0_q  <= lce0_d;
      lce1_q  <= lce1_d;
    end
  end

`ifdef BP_ME_CORD_ID_CACHE_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cache_v_q    <= 1'b0;
      cache_cord_q <= '0;
      cache_core_q <= '0;
      cache_cce_q  <= '0;
      cache_lce0_q <= '0;
      cache_lce1_q <= '0;
    end else begin
      cache_v_q    <= cache_v_d;
      cache_cord_q <= cache_cord_d;
      cache_core_q <= cache_core_d;
      cache_cce_q  <= cache_cce_d;
      cache_lce0_q <= cache_lce0_d;
      cache_lce1_q <= cache_lce1_d;
    end
  end
`endif

  assign cord_o              = cord_q;
  assign arb_if.resp_v       = (state_q == RESP);
  assign arb_if.resp_tag     = tag_q;
  assign arb_if.resp_core_id = core_q;
  assign arb_if.resp_cce_id  = cce_q;
  assign arb_if.resp_lce_id0 = lce0_q;
  assign arb_if.resp_lce_id1 = lce1_q;

endmodule

// File: tb/tb_bp_me_cord_id_req_arb.sv
// ----------------------------------------------------------------------------
// tb_bp_me_cord_id_req_arb
//   Self-checking bench for bp_me_cord_id_req_arb: a table of hand-computed
//   transactions, a reset-during-lookup sequence, then randomized requests
//   checked against a priority-queue model of the round-robin arbiter and a
//   last-cord model of the optional result cache.
// ----------------------------------------------------------------------------
module tb_bp_me_cord_id_req_arb;

  localparam int N  = 4;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bp_me_cord_id_req_arb_if #(
    .num_req_p(N), .cord_width_p(CW), .core_id_width_p(2),
    .cce_id_width_p(4), .lce_id_width_p(6), .tag_width_p(2)
  ) bus ();

  logic [CW-1:0] cord;
  logic [1:0]    core_id;
  logic [3:0]    cce_id;
  logic [5:0]    lce_id0, lce_id1;

  bp_me_cord_id_req_arb #(
    .num_req_p(N), .cord_width_p(CW), .core_id_width_p(2),
    .cce_id_width_p(4), .lce_id_width_p(6), .tag_width_p(2)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .arb_if    (bus),
    .cord_o    (cord),
    .core_id_i (core_id),
    .cce_id_i  (cce_id),
    .lce_id0_i (lce_id0),
    .lce_id1_i (lce_id1)
  );

  // Translator stub; cord 5'h05 maps to core=1, cce=1, lce0=2, lce1=3.
  function automatic logic [1:0] stub_core(input logic [4:0] c);
    return c[1:0];
  endfunction
  function automatic logic [3:0] stub_cce(input logic [4:0] c);
    return c[3:0] ^ 4'h4;
  endfunction
  function automatic logic [5:0] stub_lce0(input logic [4:0] c);
    return {1'b0, c} - 6'd3;
  endfunction
  function automatic logic [5:0] stub_lce1(input logic [4:0] c);
    return {1'b0, c} - 6'd2;
  endfunction

  assign core_id = stub_core(cord);
  assign cce_id  = stub_cce(cord);
  assign lce_id0 = stub_lce0(cord);
  assign lce_id1 = stub_lce1(cord);

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: clients in current priority order, plus last looked-up cord.
  int          order[$];
  bit          last_v;
  logic [4:0]  last_cord;

  task automatic model_reset();
    order = '{0, 1, 2, 3};
    last_v = 1'b0;
    last_cord = '0;
  endtask

  function automatic int model_pick(input logic [3:0] v);
    foreach (order[i]) if (v[order[i]]) return order[i];
    return -1;
  endfunction

  task automatic model_served(input int g, input logic [4:0] c);
    // After serving g, the client just after it has highest priority.
    while (order[0] != (g + 1) % N) order.push_back(order.pop_front());
    last_v = 1'b1;
    last_cord = c;
  endtask

  // Entry: just after a rising edge with the DUT idle. Exit: same condition.
  task automatic run_txn(input logic [3:0] v, input logic [19:0] cords,
                         input logic [3:0] exp_g, input int exp_tag,
                         input logic [4:0] exp_cord, input int delay, input bit hold);
    int lat;
    int exp_lat;
    bit hit;
    bus.req_v = v;
    bus.req_cord = cords;
    @(negedge clk);
    check("grant", bus.req_ready, exp_g);
    check("resp_v_idle", bus.resp_v, 0);
    hit = 1'b0;
`ifdef BP_ME_CORD_ID_CACHE_EN
    hit = last_v && (last_cord == exp_cord);
`endif
    exp_lat = hit ? 1 : 2;
    @(posedge clk); #1;
    if (!hold) bus.req_v = '0;
    @(negedge clk);
    check("cord_o", cord, exp_cord);
    check("ready_busy", bus.req_ready, 0);
    lat = 1;
    while (!bus.resp_v && lat < 4) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    model_served(exp_tag, exp_cord);
    check("tag", bus.resp_tag, exp_tag);
    check("core_id", bus.resp_core_id, stub_core(exp_cord));
    check("cce_id", bus.resp_cce_id, stub_cce(exp_cord));
    check("lce_id0", bus.resp_lce_id0, stub_lce0(exp_cord));
    check("lce_id1", bus.resp_lce_id1, stub_lce1(exp_cord));
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check("stall_resp_v", bus.resp_v, 1);
      check("stall_tag", bus.resp_tag, exp_tag);
      check("stall_lce1", bus.resp_lce_id1, stub_lce1(exp_cord));
      check("stall_ready", bus.req_ready, 0);
    end
    bus.resp_yumi = 1'b1;
    @(posedge clk); #1;
    bus.resp_yumi = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [19:0] cords;   // {c3, c2, c1, c0}
    logic [3:0]  g;
    int          tag;
    logic [4:0]  cord;
    int          delay;
    bit          hold;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rv;
    logic [19:0] rc;
    int          g;

    tbl[0]  = '{4'b0100, {5'h00, 5'h05, 5'h00, 5'h00}, 4'b0100, 2, 5'h05, 0,  1'b0};
    tbl[1]  = '{4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 4'b1000, 3, 5'h04, 0,  1'b1};
    tbl[2]  = '{4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 4'b0001, 0, 5'h01, 10, 1'b1};
    tbl[3]  = '{4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 4'b0010, 1, 5'h02, 0,  1'b1};
    tbl[4]  = '{4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 4'b0100, 2, 5'h03, 1,  1'b1};
    tbl[5]  = '{4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 4'b1000, 3, 5'h04, 0,  1'b0};
    tbl[6]  = '{4'b1111, {5'h04, 5'h03, 5'h02, 5'h01}, 4'b0001, 0, 5'h01, 2,  1'b0};
    tbl[7]  = '{4'b0101, {5'h00, 5'h05, 5'h00, 5'h05}, 4'b0100, 2, 5'h05, 0,  1'b0};
    tbl[8]  = '{4'b0101, {5'h00, 5'h05, 5'h00, 5'h05}, 4'b0001, 0, 5'h05, 0,  1'b0};
    tbl[9]  = '{4'b0001, {5'h00, 5'h00, 5'h00, 5'h06}, 4'b0001, 0, 5'h06, 0,  1'b0};
    tbl[10] = '{4'b1010, {5'h05, 5'h00, 5'h07, 5'h00}, 4'b0010, 1, 5'h07, 0,  1'b0};
    tbl[11] = '{4'b1010, {5'h05, 5'h00, 5'h07, 5'h00}, 4'b1000, 3, 5'h05, 0,  1'b0};

    bus.req_v = '0;
    bus.req_cord = '0;
    bus.resp_yumi = 1'b0;
    reset_n = 1'b0;
    model_reset();

    #2;
    check("rst_resp_v", bus.resp_v, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_cord", cord, 0);
    check("rst_tag", bus.resp_tag, 0);
    check("rst_ids", {bus.resp_core_id, bus.resp_cce_id, bus.resp_lce_id0, bus.resp_lce_id1}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run_txn(tbl[i].v, tbl[i].cords, tbl[i].g, tbl[i].tag, tbl[i].cord,
              tbl[i].delay, tbl[i].hold);

    // Reset while in LOOKUP: transaction dropped, outputs cleared.
    bus.req_v = 4'b0100;
    bus.req_cord = {5'h00, 5'h05, 5'h00, 5'h00};
    @(negedge clk);
    check("mid_grant", bus.req_ready, 4'b0100);
    @(posedge clk); #1;
    bus.req_v = '0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_resp_v", bus.resp_v, 0);
    check("mid_rst_cord", cord, 0);
    check("mid_rst_tag", bus.resp_tag, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_rst_hold_resp_v", bus.resp_v, 0);
      check("mid_rst_hold_ready", bus.req_ready, 0);
      check("mid_rst_hold_cord", cord, 0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("post_rst_idle_resp_v", bus.resp_v, 0);
      @(posedge clk); #1;
    end
    run_txn(4'b0100, {5'h00, 5'h05, 5'h00, 5'h00}, 4'b0100, 2, 5'h05, 0, 1'b0);
    run_txn(4'b0100, {5'h00, 5'h05, 5'h00, 5'h00}, 4'b0100, 2, 5'h05, 0, 1'b0);
    run_txn(4'b0100, {5'h00, 5'h06, 5'h00, 5'h00}, 4'b0100, 2, 5'h06, 0, 1'b0);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 60; it++) begin
      rv = 4'($urandom_range(0, 15));
      for (int c = 0; c < N; c++)
        rc[c*CW +: CW] = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h05;
      g = model_pick(rv);
      if (g < 0) begin
        bus.req_v = '0;
        bus.req_cord = rc;
        @(negedge clk);
        check("rand_idle_ready", bus.req_ready, 0);
        @(posedge clk); #1;
      end else begin
        run_txn(rv, rc, 4'(1 << g), g, rc[g*CW +: CW],
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
